// File: rtl/ysyx_220066_alu_issue_pkg.sv
// ysyx_220066_pkg: shared definitions for the ALU decode/issue stage.
//   - ALU op field codes (low 3 bits of the 5-bit aluctr word)
//   - RV64I opcode constants for the instruction classes this stage decodes
//   - entry_t: one decoded instruction as it sits in the issue queue
//   - alu_op(): maps an RV funct3 onto the ALU op field
package ysyx_220066_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SLL   = 3'd1;
  localparam logic [2:0] OP_SLT   = 3'd2;
  localparam logic [2:0] OP_PASSB = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SR    = 3'd5;
  localparam logic [2:0] OP_OR    = 3'd6;
  localparam logic [2:0] OP_AND   = 3'd7;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  aluctr;
    logic        cmp_unsigned;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
    logic [63:0] pc;
  } entry_t;

  // funct3 3 (SLTU) is not an ALU op of its own: it shares the SLT
  // comparator, and the unsigned flag travels separately.
  function automatic logic [2:0] alu_op(input logic [2:0] f3);
    logic [2:0] op;
    case (f3)
      3'd0:    op = OP_ADD;
      3'd1:    op = OP_SLL;
      3'd2:    op = OP_SLT;
      3'd3:    op = OP_SLT;
      3'd4:    op = OP_XOR;
      3'd5:    op = OP_SR;
      3'd6:    op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_220066_alu_issue_if.sv
// ysyx_220066_alu_issue_if: bundle between the issue stage and its neighbours.
//   IFU side : in_valid/in_ready handshake, in_inst, in_pc, flush
//   RF side  : rs1_addr/rs2_addr out, rs1_data/rs2_data back (same cycle)
//   EXU side : out_valid/out_ready handshake plus the decoded head entry
// modport slave is the issue stage itself; master is the surrounding core.
interface ysyx_220066_alu_issue_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [4:0]      out_aluctr;
  logic            out_cmp_unsigned;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport slave (
    input  in_valid, in_inst, in_pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_a, out_b, out_aluctr,
           out_cmp_unsigned, out_rd, out_wen, out_illegal, out_pc
  );

  modport master (
    output in_valid, in_inst, in_pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_a, out_b, out_aluctr,
           out_cmp_unsigned, out_rd, out_wen, out_illegal, out_pc
  );
endinterface

// File: rtl/ysyx_220066_alu_issue_decode.sv
// ysyx_220066_alu_issue_decode: combinational RV64I ALU-class decoder.
//   i_inst     : instruction word
//   i_pc       : instruction PC (operand A for AUIPC, carried to the entry)
//   i_rs1_data : register-file read of rs1
//   i_rs2_data : register-file read of rs2
//   o_entry    : decoded {A, B, aluctr, cmp_unsigned, rd, wen, illegal, pc}
module ysyx_220066_alu_issue_decode
  import ysyx_220066_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [63:0] i_pc,
  input  logic [63:0] i_rs1_data,
  input  logic [63:0] i_rs2_data,
  output entry_t      o_entry
);

  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [5:0]        w_f6;
  logic [4:0]        w_rd;
  logic signed [63:0] w_imm_i;
  logic signed [63:0] w_imm_u;
  logic [63:0]       w_shamt;

  assign w_opc   = i_inst[6:0];
  assign w_rd    = i_inst[11:7];
  assign w_f3    = i_inst[14:12];
  assign w_f7    = i_inst[31:25];
  assign w_f6    = i_inst[31:26];
  assign w_imm_i = {{52{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_u = {{32{i_inst[31]}}, i_inst[31:12], 12'b0};
  // Shift amounts go to the ALU clean: funct6/funct7 bits never leak into B.
  assign w_shamt = {58'b0, i_inst[25:20]};

  logic        w_legal;
  logic        w_w;
  logic        w_s;
  logic [2:0]  w_op;
  logic        w_cu;
  logic [63:0] w_a;
  logic [63:0] w_b;

  always_comb begin
    w_legal = 1'b0;
    w_w     = 1'b0;
    w_s     = 1'b0;
    w_op    = alu_op(w_f3);
    w_cu    = 1'b0;
    w_a     = i_rs1_data;
    w_b     = w_imm_i;
    case (w_opc)
      OPC_OP: begin
        w_b = i_rs2_data;
        if (w_f7 == 7'b0000000) begin
          w_legal = 1'b1;
          w_s     = (w_f3 == 3'd2) || (w_f3 == 3'd3);
          w_cu    = (w_f3 == 3'd3);
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5)) begin
          w_legal = 1'b1;
          w_s     = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        case (w_f3)
          3'd1: begin
            w_b     = w_shamt;
            w_legal = (w_f6 == 6'b000000);
          end
          3'd5: begin
            w_b     = w_shamt;
            w_legal = (w_f6 == 6'b000000) || (w_f6 == 6'b010000);
            w_s     = w_f6[4];
          end
          3'd2, 3'd3: begin
            w_legal = 1'b1;
            w_s     = 1'b1;
            w_cu    = w_f3[0];
          end
          default: w_legal = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        w_w = 1'b1;
        w_b = i_rs2_data;
        if (w_f7 == 7'b0000000 && (w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd5)) begin
          w_legal = 1'b1;
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5)) begin
          w_legal = 1'b1;
          w_s     = 1'b1;
        end
      end
      OPC_OP_IMM_32: begin
        w_w = 1'b1;
        // Checking the full funct7 here also rejects inst[25]=1 (shamt >= 32).
        case (w_f3)
          3'd0: w_legal = 1'b1;
          3'd1: begin
            w_b     = w_shamt;
            w_legal = (w_f7 == 7'b0000000);
          end
          3'd5: begin
            w_b     = w_shamt;
            w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
            w_s     = w_f7[5];
          end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_op    = OP_PASSB;
        w_b     = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_op    = OP_ADD;
        w_a     = i_pc;
        w_b     = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal instructions still flow down the queue, with an inert payload.
  always_comb begin
    o_entry              = '0;
    o_entry.rd           = w_rd;
    o_entry.pc           = i_pc;
    o_entry.illegal      = ~w_legal;
    o_entry.wen          = w_legal && (w_rd != 5'd0);
    if (w_legal) begin
      o_entry.a            = w_a;
      o_entry.b            = w_b;
      o_entry.aluctr       = {w_w, w_s, w_op};
      o_entry.cmp_unsigned = w_cu;
    end
  end

endmodule

// File: rtl/ysyx_220066_alu_issue.sv
// ysyx_220066_alu_issue: decode/issue stage feeding the integer ALU.
//   clk, rst : core clock; asynchronous active-high reset
//   bus      : ysyx_220066_alu_issue_if.slave (IFU handshake, regfile
//              address/data, flush, EXU handshake and head-entry fields)
// Decoded instructions are buffered in a 2-entry FIFO. in_ready depends only
// on the registered count, so there is no combinational out_ready->in_ready path.
module ysyx_220066_alu_issue
  import ysyx_220066_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_220066_alu_issue_if.slave      bus
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t w_dec_p0;

  assign bus.rs1_addr = bus.in_inst[19:15];
  assign bus.rs2_addr = bus.in_inst[24:20];

  ysyx_220066_alu_issue_decode u_decode (
    .i_inst     (bus.in_inst),
    .i_pc       (bus.in_pc),
    .i_rs1_data (bus.rs1_data),
    .i_rs2_data (bus.rs2_data),
    .o_entry    (w_dec_p0)
  );

  // ---- p0 -> p1: decoded entry captured into the skid queue ----
  entry_t     r_mem_p1 [DEPTH];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign bus.in_ready  = (r_count != FULL);
  assign bus.out_valid = (r_count != 2'd0);
  assign w_push        = bus.in_valid  & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem_p1[i] <= '0;
    end else if (bus.flush) begin
      // Leave the popped slot intact so the outputs keep showing it.
      r_count <= 2'd0;
      r_tail  <= r_head;
    end else begin
      if (w_push) begin
        r_mem_p1[r_tail] <= w_dec_p0;
        r_tail           <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty, the slot behind the head is the most recently popped entry.
  logic   w_sel;
  entry_t w_head;

  assign w_sel  = (r_count == 2'd0) ? ~r_head : r_head;
  assign w_head = r_mem_p1[w_sel];

  assign bus.out_a            = w_head.a[XLEN-1:0];
  assign bus.out_b            = w_head.b[XLEN-1:0];
  assign bus.out_aluctr       = w_head.aluctr;
  assign bus.out_cmp_unsigned = w_head.cmp_unsigned;
  assign bus.out_rd           = w_head.rd;
  assign bus.out_wen          = w_head.wen;
  assign bus.out_illegal      = w_head.illegal;
  assign bus.out_pc           = w_head.pc[XLEN-1:0];

endmodule
